dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-port data memory (DM) between two requesters: the CPU load/store stage (req A) and a
//  debug/loader port (req B). Fixed priority to the CPU; muxes CS/WEB/address/write data onto the DM pins.
//  Routes the one-cycle-late DM read data back to the requester that issued the read. Stalls the CPU when it loses.
// PARAMETERS
//  ADDR_W    14  DM word-address width
//  MAX_WAIT  4   consecutive denied cycles before debug is force-granted (only with DM_ARB_STARVE_EN)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  cpu_req    in   1       CPU access request (held until granted)
//  cpu_web    in   4       CPU byte write enables, active-low; 4'b1111 = read
//  cpu_addr   in   ADDR_W  CPU word address
//  cpu_wdata  in   32      CPU write data, already lane-aligned
//  cpu_gnt    out  1       CPU access issued this cycle
//  cpu_stall  out  1       cpu_req & ~cpu_gnt
//  cpu_rvalid out  1       CPU read data valid (cycle after granted read)
//  cpu_rdata  out  32      CPU read data
//  dbg_req    in   1       debug access request (held until granted)
//  dbg_lock   in   1       keep ownership after current grant (burst)
//  dbg_web    in   4       debug byte write enables, active-low
//  dbg_addr   in   ADDR_W  debug word address
//  dbg_wdata  in   32      debug write data
//  dbg_gnt    out  1       debug access issued this cycle
//  dbg_rvalid out  1       debug read data valid
//  dbg_rdata  out  32      debug read data
//  dm_cs      out  1       DM chip select
//  dm_web     out  4       DM byte write enables, active-low
//  dm_addr    out  ADDR_W  DM address
//  dm_di      out  32      DM write data
//  dm_do      in   32      DM read data (valid cycle after access)
// BEHAVIOUR
//  - Transfer occurs in a cycle with req & gnt; gnt is combinational from req and state; one grant max per cycle.
//  - FSM (owner) states: IDLE, CPU, DBG, DBG_LOCK. State = who was granted last cycle.
//    * any state except DBG_LOCK: cpu_req -> grant CPU; else dbg_req -> grant DBG; else none.
//    * DBG_LOCK: only debug may be granted; CPU stalls. Exit to IDLE when dbg_lock=0 or dbg_req=0 that cycle.
//    * Next state: CPU if CPU granted; DBG_LOCK if debug granted and dbg_lock=1; DBG if debug granted; else IDLE.
//  - DM pins: granted side's web/addr/wdata, dm_cs=1. No grant: dm_cs=0, dm_web=4'b1111, addr/di=0.
//  - Read tracking: rd_owner reg <= {cpu granted & web==1111, dbg granted & web==1111}. x_rvalid = rd_owner bit;
//    x_rdata = dm_do when x_rvalid else 32'b0. Writes produce no rvalid.
//  - Back-to-back: new grant may issue while previous read data returns (latency 1, throughput 1/cycle).
//  - Simultaneous req in IDLE/CPU/DBG: CPU wins; debug sees dbg_gnt=0 and must hold request.
//  - Reset (any time, incl. mid-burst): state=IDLE, rd_owner=0, wait counter=0; thus rvalids=0, rdata=0;
//    combinational outputs follow inputs with IDLE state. In-flight read data is discarded.
// CONFIGURATION
//  - DM_ARB_STARVE_EN defined: counter wait_cnt (clog2(MAX_WAIT+1) bits) increments each cycle dbg_req & ~dbg_gnt,
//    clears on dbg_gnt or ~dbg_req; saturates at MAX_WAIT. When wait_cnt==MAX_WAIT, debug wins over CPU for one
//    grant (CPU stalls), counter clears.
//  - Not defined: no counter, pure CPU priority; debug may starve indefinitely under continuous CPU traffic.
// STRUCTURE
//  - Package dm_arb_pkg: typedef enum logic [1:0] owner_e {IDLE,CPU,DBG,DBG_LOCK}; localparam WEB_RD = 4'b1111;
//    localparam DATA_W = 32.
//  - One sub-module: dm_arb_starve_cnt (wait counter + force flag), instantiated only under DM_ARB_STARVE_EN.
//  - Top: owner FSM, grant logic, DM mux, rd_owner register.
// TESTING
//  - CPU read addr 0x10, dbg idle -> cycle0 cpu_gnt=1, dm_cs=1, dm_web=1111; cycle1 cpu_rvalid=1, cpu_rdata=dm_do.
//  - CPU+dbg req same cycle (dbg write 0xA5A5A5A5) -> cpu_gnt=1, dbg_gnt=0; next cycle (cpu_req=0) dbg_gnt=1,
//    dm_di=0xA5A5A5A5, dbg_rvalid never set.
//  - dbg_lock=1 with 3-beat burst while cpu_req=1 -> dbg_gnt 3 consecutive cycles, cpu_stall=1; lock drops ->
//    CPU granted next cycle.
//  - DM_ARB_STARVE_EN, MAX_WAIT=4, cpu_req constant, dbg_req held -> dbg_gnt=1 on 5th cycle, cpu_stall=1 that
//    cycle only; without macro dbg_gnt stays 0 for 20 cycles.
//  - rst asserted mid-burst, after a dbg read grant -> next cycle dbg_rvalid=0, dbg_rdata=0, state IDLE, CPU
//    granted first after release.
//  - Alternating CPU read/dbg read every cycle -> rvalid routed to the correct side each cycle, no crossover.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Owner states record which requester was granted in the previous cycle.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU,
        DBG,
        DBG_LOCK
    } owner_e;

    localparam logic [3:0] WEB_RD = 4'b1111;
    localparam int         DATA_W = 32;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of CPU, debug and DM pin signals around the arbiter.
// "slave" is the arbiter's view; "master" is the requesters/memory side.
interface dm_port_arbiter_if #(
    parameter int ADDR_W = 14
);
    import dm_arb_pkg::*;

    logic              cpu_req;
    logic [3:0]        cpu_web;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_lock;
    logic [3:0]        dbg_web;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              dm_cs;
    logic [3:0]        dm_web;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_di;
    logic [DATA_W-1:0] dm_do;

    modport slave (
        input  cpu_req, cpu_web, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_lock, dbg_web, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output dm_cs, dm_web, dm_addr, dm_di,
        input  dm_do
    );

    modport master (
        output cpu_req, cpu_web, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_lock, dbg_web, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  dm_cs, dm_web, dm_addr, dm_di,
        output dm_do
    );

endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Debug starvation counter: counts consecutive denied debug cycles and
// raises force_dbg once MAX_WAIT is reached (used with DM_ARB_STARVE_EN).
module dm_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    // Saturating count; force_dbg depends only on the register, so the
    // grant logic that consumes it never forms a combinational loop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!dbg_req || dbg_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_dbg = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-requester arbiter for the single-port data memory: CPU has fixed
// priority, debug can lock bursts. Optional starvation guard: DM_ARB_STARVE_EN.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 14
`ifdef DM_ARB_STARVE_EN
    , parameter int MAX_WAIT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    dm_port_arbiter_if.slave  bus
);

    owner_e     state;
    logic [1:0] rd_owner;
    logic       cpu_gnt;
    logic       dbg_gnt;
    logic       force_dbg;

`ifdef DM_ARB_STARVE_EN
    dm_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk       (clk),
        .rst       (rst),
        .dbg_req   (bus.dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (state == DBG_LOCK) begin
            dbg_gnt = bus.dbg_req;
        end else if (force_dbg && bus.dbg_req) begin
            dbg_gnt = 1'b1;
        end else if (bus.cpu_req) begin
            cpu_gnt = 1'b1;
        end else begin
            dbg_gnt = bus.dbg_req;
        end
    end

    assign bus.cpu_gnt   = cpu_gnt;
    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

    always_comb begin
        bus.dm_cs   = 1'b0;
        bus.dm_web  = WEB_RD;
        bus.dm_addr = {ADDR_W{1'b0}};
        bus.dm_di   = '0;
        if (cpu_gnt) begin
            bus.dm_cs   = 1'b1;
            bus.dm_web  = bus.cpu_web;
            bus.dm_addr = bus.cpu_addr;
            bus.dm_di   = bus.cpu_wdata;
        end else if (dbg_gnt) begin
            bus.dm_cs   = 1'b1;
            bus.dm_web  = bus.dbg_web;
            bus.dm_addr = bus.dbg_addr;
            bus.dm_di   = bus.dbg_wdata;
        end
    end

    // rd_owner remembers who issued a read so the late DM data returns to them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rd_owner <= 2'b00;
        end else begin
            if (cpu_gnt) begin
                state <= CPU;
            end else if (dbg_gnt) begin
                state <= bus.dbg_lock ? DBG_LOCK : DBG;
            end else begin
                state <= IDLE;
            end
            rd_owner <= {cpu_gnt && (bus.cpu_web == WEB_RD),
                         dbg_gnt && (bus.dbg_web == WEB_RD)};
        end
    end

    assign bus.cpu_rvalid = rd_owner[1];
    assign bus.dbg_rvalid = rd_owner[0];
    assign bus.cpu_rdata  = rd_owner[1] ? bus.dm_do : '0;
    assign bus.dbg_rdata  = rd_owner[0] ? bus.dm_do : '0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed self-checking bench for dm_port_arbiter: vector table plus
// hand-written starvation and reset-mid-burst sequences.
module tb_dm_port_arbiter;
    import dm_arb_pkg::*;

    localparam logic [3:0] RD = 4'hF;

    typedef struct {
        logic        cpu_req;
        logic [3:0]  cpu_web;
        logic [13:0] cpu_addr;
        logic [31:0] cpu_wdata;
        logic        dbg_req;
        logic        dbg_lock;
        logic [3:0]  dbg_web;
        logic [13:0] dbg_addr;
        logic [31:0] dbg_wdata;
        logic [31:0] dm_do;
        logic        exp_cpu_gnt;
        logic        exp_cpu_stall;
        logic        exp_dbg_gnt;
        logic        exp_cpu_rvalid;
        logic [31:0] exp_cpu_rdata;
        logic        exp_dbg_rvalid;
        logic [31:0] exp_dbg_rdata;
        logic        exp_dm_cs;
        logic [3:0]  exp_dm_web;
        logic [13:0] exp_dm_addr;
        logic [31:0] exp_dm_di;
    } vec_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;
    vec_t vecs [17];

    dm_port_arbiter_if #(.ADDR_W(14)) bus ();

    dm_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bus.cpu_req   = v.cpu_req;
        bus.cpu_web   = v.cpu_web;
        bus.cpu_addr  = v.cpu_addr;
        bus.cpu_wdata = v.cpu_wdata;
        bus.dbg_req   = v.dbg_req;
        bus.dbg_lock  = v.dbg_lock;
        bus.dbg_web   = v.dbg_web;
        bus.dbg_addr  = v.dbg_addr;
        bus.dbg_wdata = v.dbg_wdata;
        bus.dm_do     = v.dm_do;
    endtask

    task automatic drive_idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_web   = RD;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_lock  = 1'b0;
        bus.dbg_web   = RD;
        bus.dbg_addr  = '0;
        bus.dbg_wdata = '0;
        bus.dm_do     = '0;
    endtask

    task automatic check_vector(input int i, input vec_t v);
        check_output($sformatf("v%0d cpu_gnt", i),    32'(bus.cpu_gnt),    32'(v.exp_cpu_gnt));
        check_output($sformatf("v%0d cpu_stall", i),  32'(bus.cpu_stall),  32'(v.exp_cpu_stall));
        check_output($sformatf("v%0d dbg_gnt", i),    32'(bus.dbg_gnt),    32'(v.exp_dbg_gnt));
        check_output($sformatf("v%0d cpu_rvalid", i), 32'(bus.cpu_rvalid), 32'(v.exp_cpu_rvalid));
        check_output($sformatf("v%0d cpu_rdata", i),  bus.cpu_rdata,       v.exp_cpu_rdata);
        check_output($sformatf("v%0d dbg_rvalid", i), 32'(bus.dbg_rvalid), 32'(v.exp_dbg_rvalid));
        check_output($sformatf("v%0d dbg_rdata", i),  bus.dbg_rdata,       v.exp_dbg_rdata);
        check_output($sformatf("v%0d dm_cs", i),      32'(bus.dm_cs),      32'(v.exp_dm_cs));
        check_output($sformatf("v%0d dm_web", i),     32'(bus.dm_web),     32'(v.exp_dm_web));
        check_output($sformatf("v%0d dm_addr", i),    32'(bus.dm_addr),    32'(v.exp_dm_addr));
        check_output($sformatf("v%0d dm_di", i),      bus.dm_di,           v.exp_dm_di);
    endtask

    initial begin
        logic exp_dbg;

        tests_run    = 0;
        tests_failed = 0;

        // inputs: cpu_req web addr wdata | dbg_req lock web addr wdata | dm_do
        // expect: cpu_gnt stall dbg_gnt cpu_rv cpu_rd dbg_rv dbg_rd cs web addr di
        vecs[0]  = '{1'b1, RD, 14'h10, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, RD, 14'h10, 32'h0};
        vecs[1]  = '{1'b0, RD, 14'h0, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h12345678,
                     1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0, RD, 14'h0, 32'h0};
        vecs[2]  = '{1'b1, RD, 14'h20, 32'h0, 1'b1, 1'b0, 4'h0, 14'h30, 32'hA5A5A5A5, 32'hFFFF0000,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, RD, 14'h20, 32'h0};
        vecs[3]  = '{1'b0, RD, 14'h0, 32'h0, 1'b1, 1'b0, 4'h0, 14'h30, 32'hA5A5A5A5, 32'h0BADF00D,
                     1'b0, 1'b0, 1'b1, 1'b1, 32'h0BADF00D, 1'b0, 32'h0, 1'b1, 4'h0, 14'h30, 32'hA5A5A5A5};
        vecs[4]  = '{1'b0, RD, 14'h0, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h11111111,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, RD, 14'h0, 32'h0};
        vecs[5]  = '{1'b1, RD, 14'h40, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h22222222,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, RD, 14'h40, 32'h0};
        vecs[6]  = '{1'b0, RD, 14'h0, 32'h0, 1'b1, 1'b0, RD, 14'h50, 32'h0, 32'h33333333,
                     1'b0, 1'b0, 1'b1, 1'b1, 32'h33333333, 1'b0, 32'h0, 1'b1, RD, 14'h50, 32'h0};
        vecs[7]  = '{1'b1, RD, 14'h44, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h44444444,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h44444444, 1'b1, RD, 14'h44, 32'h0};
        vecs[8]  = '{1'b0, RD, 14'h0, 32'h0, 1'b1, 1'b0, RD, 14'h54, 32'h0, 32'h55555555,
                     1'b0, 1'b0, 1'b1, 1'b1, 32'h55555555, 1'b0, 32'h0, 1'b1, RD, 14'h54, 32'h0};
        vecs[9]  = '{1'b0, RD, 14'h0, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h66666666,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h66666666, 1'b0, RD, 14'h0, 32'h0};
        vecs[10] = '{1'b1, 4'hC, 14'h60, 32'hCAFEBABE, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h0,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 4'hC, 14'h60, 32'hCAFEBABE};
        vecs[11] = '{1'b0, RD, 14'h0, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'h77777777,
                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, RD, 14'h0, 32'h0};
        vecs[12] = '{1'b0, RD, 14'h0, 32'h0, 1'b1, 1'b1, RD, 14'h70, 32'h0, 32'h0,
                     1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, RD, 14'h70, 32'h0};
        vecs[13] = '{1'b1, RD, 14'h80, 32'h0, 1'b1, 1'b1, RD, 14'h71, 32'h0, 32'h88888888,
                     1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h88888888, 1'b1, RD, 14'h71, 32'h0};
        vecs[14] = '{1'b1, RD, 14'h80, 32'h0, 1'b1, 1'b0, RD, 14'h72, 32'h0, 32'h99999999,
                     1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h99999999, 1'b1, RD, 14'h72, 32'h0};
        vecs[15] = '{1'b1, RD, 14'h80, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'hAAAA0000,
                     1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA0000, 1'b1, RD, 14'h80, 32'h0};
        vecs[16] = '{1'b0, RD, 14'h0, 32'h0, 1'b0, 1'b0, RD, 14'h0, 32'h0, 32'hBBBB0000,
                     1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBB0000, 1'b0, 32'h0, 1'b0, RD, 14'h0, 32'h0};

        rst = 1'b1;
        drive_idle();
        bus.dm_do = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        #1;
        check_output("reset cpu_rvalid", 32'(bus.cpu_rvalid), 32'h0);
        check_output("reset dbg_rdata",  bus.dbg_rdata,       32'h0);
        check_output("reset dm_cs",      32'(bus.dm_cs),      32'h0);
        check_output("reset dm_web",     32'(bus.dm_web),     32'hF);
        @(negedge clk);
        rst = 1'b0;
        bus.dm_do = '0;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i]);
            #1;
            check_vector(i, vecs[i]);
        end

        // Continuous CPU traffic against a held debug read.
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            drive_idle();
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = 14'h100;
            bus.dbg_req  = 1'b1;
            bus.dbg_addr = 14'h200;
            #1;
`ifdef DM_ARB_STARVE_EN
            exp_dbg = ((k % 5) == 0);
`else
            exp_dbg = 1'b0;
`endif
            check_output($sformatf("starve c%0d dbg_gnt", k),   32'(bus.dbg_gnt),   32'(exp_dbg));
            check_output($sformatf("starve c%0d cpu_stall", k), 32'(bus.cpu_stall), 32'(exp_dbg));
            check_output($sformatf("starve c%0d cpu_gnt", k),   32'(bus.cpu_gnt),   32'(!exp_dbg));
        end

        // Reset during a locked debug burst, right after a debug read grant.
        @(negedge clk);
        drive_idle();
        bus.dbg_req  = 1'b1;
        bus.dbg_lock = 1'b1;
        bus.dbg_addr = 14'h300;
        #1;
        check_output("burst dbg_gnt", 32'(bus.dbg_gnt), 32'h1);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.dm_do    = 32'hDEADBEEF;
        #1;
        check_output("rst dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
        check_output("rst dbg_rdata",  bus.dbg_rdata,       32'h0);
        check_output("rst cpu_gnt",    32'(bus.cpu_gnt),    32'h1);
        check_output("rst dbg_gnt",    32'(bus.dbg_gnt),    32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_output("post-rst cpu_gnt",   32'(bus.cpu_gnt),   32'h1);
        check_output("post-rst dbg_gnt",   32'(bus.dbg_gnt),   32'h0);
        check_output("post-rst cpu_stall", 32'(bus.cpu_stall), 32'h0);

        @(negedge clk);
        drive_idle();
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
